turnstile_access_scheduler: RTL and testbench

Round-robin scheduler that shares one access-code validator and one door-actuator driver among `N_GATES` metro turnstile card readers. It grants one pending reader at a time, checks the reader's 4-bit code against `VALID_CODE` and drives that gate's door open for a fixed time. It also counts consecutive failed attempts per gate and locks a gate out for a fixed time after `MAX_FAIL` failures. It sits between the reader front-ends and the gate actuators in the turnstile subsystem.

---
 rtl/turnstile_access_scheduler.sv | 175 +++++++++++++++++
 tb/tb_turnstile_access_scheduler.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turnstile_access_scheduler.sv
// Round-robin arbiter sharing one code validator and one door driver among N_GATES turnstile readers.
// Tracks consecutive failures per gate and locks a gate out for LOCK_CYCLES after MAX_FAIL of them.
//
// state | meaning
// IDLE  | sampling req & ~locked, grants the next gate in round-robin order
// CHECK | one cycle: compare latched code, update fail count / lock timer
// OPEN  | door_open held for OPEN_CYCLES cycles
module turnstile_access_scheduler #(
  parameter int         N_GATES     = 4,
  parameter logic [3:0] VALID_CODE  = 4'd9,
  parameter int         OPEN_CYCLES = 8,
  parameter int         MAX_FAIL    = 3,
  parameter int         LOCK_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_GATES-1:0]     req,
  input  logic [4*N_GATES-1:0]   code_in,
  output logic [N_GATES-1:0]     ack,
  output logic [N_GATES-1:0]     door_open,
  output logic [N_GATES-1:0]     locked,
  output logic                   busy,
  output logic [1:0]             state_out
);

  localparam int GW = $clog2(N_GATES);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int OW = $clog2(OPEN_CYCLES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_OPEN  = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       gate_q, gate_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [3:0]          code_q, code_d;
  logic [OW-1:0]       open_tmr_q, open_tmr_d;
  logic [FW-1:0]       fail_cnt_q [N_GATES];
  logic [FW-1:0]       fail_cnt_d [N_GATES];
  logic [LW-1:0]       lock_tmr_q [N_GATES];
  logic [LW-1:0]       lock_tmr_d [N_GATES];
  logic [N_GATES-1:0]  ack_q, ack_d;
  logic [N_GATES-1:0]  door_open_q, door_open_d;
  logic [N_GATES-1:0]  locked_q, locked_d;
  logic                busy_q, busy_d;

  logic [N_GATES-1:0]  elig;
  logic                grant_vld;
  logic [GW-1:0]       grant_sel;
  logic [3:0]          code_sel;
  logic [FW-1:0]       fail_inc;

  function automatic logic [GW-1:0] gate_after(input logic [GW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_GATES) s = s - N_GATES;
    return GW'(s);
  endfunction

  assign elig = req & ~locked_q;

  // Walk offsets downward so the smallest offset from the pointer wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = ptr_q;
    for (int i = N_GATES - 1; i >= 0; i--) begin
      if (elig[gate_after(ptr_q, i)]) begin
        grant_vld = 1'b1;
        grant_sel = gate_after(ptr_q, i);
      end
    end
    code_sel = '0;
    for (int i = 0; i < N_GATES; i++) begin
      if (grant_sel == GW'(i)) code_sel = code_in[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gate_q      <= '0;
      ptr_q       <= '0;
      code_q      <= '0;
      open_tmr_q  <= '0;
      ack_q       <= '0;
      door_open_q <= '0;
      locked_q    <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < N_GATES; i++) begin
        fail_cnt_q[i] <= '0;
        lock_tmr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      gate_q      <= gate_d;
      ptr_q       <= ptr_d;
      code_q      <= code_d;
      open_tmr_q  <= open_tmr_d;
      ack_q       <= ack_d;
      door_open_q <= door_open_d;
      locked_q    <= locked_d;
      busy_q      <= busy_d;
      for (int i = 0; i < N_GATES; i++) begin
        fail_cnt_q[i] <= fail_cnt_d[i];
        lock_tmr_q[i] <= lock_tmr_d[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    ptr_d      = ptr_q;
    code_d     = code_q;
    open_tmr_d = open_tmr_q;
    fail_cnt_d = fail_cnt_q;
    for (int i = 0; i < N_GATES; i++) begin
      lock_tmr_d[i] = (lock_tmr_q[i] != '0) ? lock_tmr_q[i] - LW'(1) : '0;
    end
    fail_inc = fail_cnt_q[gate_q] + FW'(1);
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d = ST_CHECK;
          gate_d  = grant_sel;
          ptr_d   = gate_after(grant_sel, 1);
          code_d  = code_sel;
        end
      end
      ST_CHECK: begin
        if (code_q == VALID_CODE) begin
          fail_cnt_d[gate_q] = '0;
          open_tmr_d         = OW'(OPEN_CYCLES);
          state_d            = ST_OPEN;
        end else begin
          state_d = ST_IDLE;
          if (fail_inc == FW'(MAX_FAIL)) begin
            fail_cnt_d[gate_q] = '0;
            lock_tmr_d[gate_q] = LW'(LOCK_CYCLES);
          end else begin
            fail_cnt_d[gate_q] = fail_inc;
          end
        end
      end
      ST_OPEN: begin
        if (open_tmr_q == OW'(1)) state_d = ST_IDLE;
        else                      open_tmr_d = open_tmr_q - OW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered copies of next-state decodes so they line up with state_q.
  always_comb begin
    ack_d       = '0;
    door_open_d = '0;
    if (state_q == ST_IDLE && grant_vld) ack_d[grant_sel] = 1'b1;
    if (state_d == ST_OPEN) door_open_d[gate_d] = 1'b1;
    busy_d = (state_d != ST_IDLE);
    for (int i = 0; i < N_GATES; i++) begin
      locked_d[i] = (lock_tmr_d[i] != '0);
    end
  end

  assign ack       = ack_q;
  assign door_open = door_open_q;
  assign locked    = locked_q;
  assign busy      = busy_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_turnstile_access_scheduler.sv
// Bench for turnstile_access_scheduler: directed scenarios plus random traffic,
// all compared cycle by cycle against a timestamp-based transaction model.
module tb_turnstile_access_scheduler;
  localparam int         N    = 4;
  localparam logic [3:0] VC   = 4'd9;
  localparam int         OPEN = 8;
  localparam int         MAXF = 3;
  localparam int         LOCK = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [4*N-1:0] code_in = '0;
  logic [N-1:0]   ack, door_open, locked;
  logic           busy;
  logic [1:0]     state_out;

  int checks = 0;
  int errors = 0;

  turnstile_access_scheduler #(
    .N_GATES(N), .VALID_CODE(VC), .OPEN_CYCLES(OPEN), .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .code_in(code_in),
    .ack(ack), .door_open(door_open), .locked(locked), .busy(busy), .state_out(state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Transaction model: every grant is a timestamp; door window, next legal
  // sample and lock window follow from the grant edge by plain arithmetic.
  int m_cyc, m_next, m_gcyc, m_ggate, m_open_lo, m_open_hi, m_ptr, m_pick, m_gg;
  int m_fail [N];
  int m_lock [N];
  logic [N-1:0] exp_ack, exp_door, exp_locked;
  logic         exp_busy;
  logic [1:0]   exp_state;

  function automatic bit m_locked(int g, int t);
    return (t >= m_lock[g]) && (t < m_lock[g] + LOCK);
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_next = 0; m_gcyc = -100; m_ggate = 0;
    m_open_lo = -100; m_open_hi = -100; m_ptr = 0;
    for (int g = 0; g < N; g++) begin
      m_fail[g] = 0;
      m_lock[g] = -1000;
    end
    exp_ack = '0; exp_door = '0; exp_locked = '0; exp_busy = 1'b0; exp_state = 2'b00;
  endtask

  task automatic model_eval();
    logic [3:0] c;
    m_cyc  = m_cyc + 1;
    m_pick = -1;
    if (m_cyc >= m_next) begin
      for (int k = N - 1; k >= 0; k--) begin
        m_gg = (m_ptr + k) % N;
        if (1'(req >> m_gg) && !m_locked(m_gg, m_cyc - 1)) m_pick = m_gg;
      end
    end
    if (m_pick >= 0) begin
      m_gcyc  = m_cyc;
      m_ggate = m_pick;
      m_ptr   = (m_pick + 1) % N;
      c = 4'(code_in >> (4 * m_pick));
      if (c == VC) begin
        m_fail[m_pick] = 0;
        m_open_lo = m_cyc + 1;
        m_open_hi = m_cyc + 1 + OPEN;
        m_next    = m_cyc + OPEN + 2;
      end else begin
        m_fail[m_pick] = m_fail[m_pick] + 1;
        if (m_fail[m_pick] == MAXF) begin
          m_fail[m_pick] = 0;
          m_lock[m_pick] = m_cyc + 1;
        end
        m_next = m_cyc + 2;
      end
    end
    exp_ack  = (m_gcyc == m_cyc) ? (N'(1) << m_ggate) : '0;
    exp_door = (m_cyc >= m_open_lo && m_cyc < m_open_hi) ? (N'(1) << m_ggate) : '0;
    if (m_gcyc == m_cyc)                              exp_state = 2'b01;
    else if (m_cyc >= m_open_lo && m_cyc < m_open_hi) exp_state = 2'b10;
    else                                              exp_state = 2'b00;
    exp_busy   = (exp_state != 2'b00);
    exp_locked = '0;
    for (int g = 0; g < N; g++) exp_locked = exp_locked | (N'(m_locked(g, m_cyc)) << g);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_eval();
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ack, door_open, locked, busy, state_out} !== '0) begin
      errors++;
      $display("FAIL reset_values got ack=%b door=%b lck=%b busy=%b st=%b want all 0", ack, door_open, locked, busy, state_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ack, door_open, locked, busy, state_out} !== {exp_ack, exp_door, exp_locked, exp_busy, exp_state}) begin
      errors++;
      $display("FAIL reset_idle got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", ack, door_open, locked, busy, state_out, exp_ack, exp_door, exp_locked, exp_busy, exp_state);
    end
  endtask

  task automatic test_single_open();
    int n_ack = 0, n_door = 0;
    bit saw_check = 0, saw_open = 0;
    code_in[3:0] = 4'd9;
    req[0] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      checks++;
      if ({ack, door_open, locked, busy, state_out} !== {exp_ack, exp_door, exp_locked, exp_busy, exp_state}) begin
        errors++;
        $display("FAIL single_open t=%0t got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", $time, ack, door_open, locked, busy, state_out, exp_ack, exp_door, exp_locked, exp_busy, exp_state);
      end
      if (ack[0]) begin n_ack++; req[0] = 1'b0; end
      if (door_open[0]) n_door++;
      if (state_out == 2'b01) saw_check = 1;
      if (state_out == 2'b10) saw_open = 1;
    end
    checks++;
    if (n_ack != 1 || n_door != OPEN || !saw_check || !saw_open) begin
      errors++;
      $display("FAIL single_open_counts got ack=%0d door=%0d chk=%0d open=%0d want 1 %0d 1 1", n_ack, n_door, saw_check, saw_open, OPEN);
    end
  endtask

  task automatic test_lockout();
    bit got;
    int cyc = 0, lock_len = 0, t_fall = -1, t_ack = -1;
    bit ack_in_lock = 0;
    code_in[11:8] = 4'd0;
    for (int a = 0; a < MAXF; a++) begin
      req[2] = 1'b1;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        checks++;
        if ({ack, door_open, locked, busy, state_out} !== {exp_ack, exp_door, exp_locked, exp_busy, exp_state}) begin
          errors++;
          $display("FAIL lockout_attempt t=%0t got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", $time, ack, door_open, locked, busy, state_out, exp_ack, exp_door, exp_locked, exp_busy, exp_state);
        end
        if (ack[2]) begin got = 1; req[2] = 1'b0; end
        if (door_open[2]) begin errors++; $display("FAIL lockout_door got door=%b want 0000", door_open); end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL lockout_ack attempt %0d got none want ack[2]", a); end
      @(negedge clk);
      checks++;
      if ({ack, door_open, locked, busy, state_out} !== {exp_ack, exp_door, exp_locked, exp_busy, exp_state}) begin
        errors++;
        $display("FAIL lockout_gap t=%0t got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", $time, ack, door_open, locked, busy, state_out, exp_ack, exp_door, exp_locked, exp_busy, exp_state);
      end
    end
    lock_len = int'(locked[2]);
    req[2] = 1'b1;
    for (int c = 0; c < 30 && t_ack < 0; c++) begin
      @(negedge clk);
      cyc++;
      checks++;
      if ({ack, door_open, locked, busy, state_out} !== {exp_ack, exp_door, exp_locked, exp_busy, exp_state}) begin
        errors++;
        $display("FAIL lockout_hold t=%0t got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", $time, ack, door_open, locked, busy, state_out, exp_ack, exp_door, exp_locked, exp_busy, exp_state);
      end
      if (locked[2]) lock_len++;
      if (locked[2] && ack[2]) ack_in_lock = 1;
      if (!locked[2] && t_fall < 0) t_fall = cyc;
      if (ack[2]) begin t_ack = cyc; req[2] = 1'b0; end
    end
    checks++;
    if (lock_len != LOCK || ack_in_lock || t_fall < 0 || t_ack != t_fall + 1) begin
      errors++;
      $display("FAIL lockout_window got len=%0d ack_in_lock=%0d fall=%0d ack=%0d want len=%0d 0 ack=fall+1", lock_len, ack_in_lock, t_fall, t_ack, LOCK);
    end
    for (int c = 0; c < 3; c++) @(negedge clk);
  endtask

  task automatic test_fail_clear();
    logic [3:0] codes [5] = '{4'd0, 4'd0, 4'd9, 4'd0, 4'd0};
    bit got;
    bit saw_lock = 0;
    for (int a = 0; a < 5; a++) begin
      code_in[7:4] = codes[a];
      req[1] = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        checks++;
        if ({ack, door_open, locked, busy, state_out} !== {exp_ack, exp_door, exp_locked, exp_busy, exp_state}) begin
          errors++;
          $display("FAIL fail_clear t=%0t got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", $time, ack, door_open, locked, busy, state_out, exp_ack, exp_door, exp_locked, exp_busy, exp_state);
        end
        saw_lock = saw_lock | locked[1];
        if (ack[1]) begin got = 1; req[1] = 1'b0; end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL fail_clear_ack attempt %0d got none want ack[1]", a); end
      @(negedge clk);
      saw_lock = saw_lock | locked[1];
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      saw_lock = saw_lock | locked[1];
    end
    checks++;
    if (saw_lock !== 1'b0) begin errors++; $display("FAIL fail_clear_nolock got locked[1] seen=%b want 0", saw_lock); end
  endtask

  task automatic test_busy_pending();
    int cyc = 0, n_door = 0, t_last_door = -1, t_ack3 = -1;
    bit got = 0, ack3_during_door = 0;
    code_in[3:0]   = 4'd9;
    code_in[15:12] = 4'd5;
    req[0] = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      cyc++;
      if (ack[0]) begin got = 1; req[0] = 1'b0; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL busy_ack0 got none want ack[0]"); end
    for (int c = 0; c < 30 && t_ack3 < 0; c++) begin
      @(negedge clk);
      cyc++;
      checks++;
      if ({ack, door_open, locked, busy, state_out} !== {exp_ack, exp_door, exp_locked, exp_busy, exp_state}) begin
        errors++;
        $display("FAIL busy_pending t=%0t got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", $time, ack, door_open, locked, busy, state_out, exp_ack, exp_door, exp_locked, exp_busy, exp_state);
      end
      if (c == 2) req[3] = 1'b1;
      if (door_open[0]) begin n_door++; t_last_door = cyc; end
      if (ack[3] && door_open[0]) ack3_during_door = 1;
      if (ack[3]) begin t_ack3 = cyc; req[3] = 1'b0; end
    end
    checks++;
    if (n_door != OPEN || ack3_during_door || t_ack3 != t_last_door + 2) begin
      errors++;
      $display("FAIL busy_defer got door_cycles=%0d overlap=%0d ack3=%0d last_door=%0d want %0d 0 ack3=last_door+2", n_door, ack3_during_door, t_ack3, t_last_door, OPEN);
    end
    for (int c = 0; c < 3; c++) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int grants [5];
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int ng = 0;
    do_reset();
    code_in = {4{4'd9}};
    req = '1;
    for (int c = 0; c < 80 && ng < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({ack, door_open, locked, busy, state_out} !== {exp_ack, exp_door, exp_locked, exp_busy, exp_state}) begin
        errors++;
        $display("FAIL back_to_back t=%0t got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", $time, ack, door_open, locked, busy, state_out, exp_ack, exp_door, exp_locked, exp_busy, exp_state);
      end
      checks++;
      if ($countones(door_open) > 1 || $countones(ack) > 1) begin
        errors++;
        $display("FAIL b2b_onehot got door=%b ack=%b want at most one bit", door_open, ack);
      end
      if (ack != '0) begin
        for (int k = 0; k < N; k++) if (1'(ack >> k)) grants[ng] = k;
        ng++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= ng || grants[k] != exp_order[k]) begin
        errors++;
        $display("FAIL b2b_order grant %0d got %0d want %0d (granted %0d)", k, (k < ng) ? grants[k] : -1, exp_order[k], ng);
      end
    end
    req = '0;
    for (int c = 0; c < 12; c++) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit got;
    code_in[3:0] = 4'd9;
    req[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ack[0]) begin got = 1; req[0] = 1'b0; end
    end
    for (int c = 0; c < 3; c++) @(negedge clk);
    checks++;
    if (door_open !== 4'b0001) begin errors++; $display("FAIL mid_open_setup got door=%b want 0001", door_open); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, door_open, locked, busy, state_out} !== '0) begin
      errors++;
      $display("FAIL mid_open_reset got ack=%b door=%b lck=%b busy=%b st=%b want all 0", ack, door_open, locked, busy, state_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    code_in[7:4] = 4'd0;
    for (int a = 0; a < MAXF; a++) begin
      req[1] = 1'b1;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        checks++;
        if ({ack, door_open, locked, busy, state_out} !== {exp_ack, exp_door, exp_locked, exp_busy, exp_state}) begin
          errors++;
          $display("FAIL mid_lock_attempt t=%0t got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", $time, ack, door_open, locked, busy, state_out, exp_ack, exp_door, exp_locked, exp_busy, exp_state);
        end
        if (ack[1]) begin got = 1; req[1] = 1'b0; end
      end
      @(negedge clk);
    end
    code_in[7:4] = 4'd9;
    req[1] = 1'b1;
    for (int c = 0; c < 4; c++) @(negedge clk);
    checks++;
    if (locked !== 4'b0010 || ack !== '0) begin
      errors++;
      $display("FAIL mid_lock_setup got locked=%b ack=%b want 0010 0000", locked, ack);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, door_open, locked, busy, state_out} !== '0) begin
      errors++;
      $display("FAIL mid_lock_reset got ack=%b door=%b lck=%b busy=%b st=%b want all 0", ack, door_open, locked, busy, state_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0010 || state_out !== 2'b01) begin
      errors++;
      $display("FAIL mid_regrant got ack=%b st=%b want 0010 01", ack, state_out);
    end
    req[1] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if ({ack, door_open, locked, busy, state_out} !== {exp_ack, exp_door, exp_locked, exp_busy, exp_state}) begin
        errors++;
        $display("FAIL mid_drain t=%0t got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", $time, ack, door_open, locked, busy, state_out, exp_ack, exp_door, exp_locked, exp_busy, exp_state);
      end
    end
  endtask

  task automatic test_random();
    bit r;
    logic [3:0] c;
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      checks++;
      if ({ack, door_open, locked, busy, state_out} !== {exp_ack, exp_door, exp_locked, exp_busy, exp_state}) begin
        errors++;
        $display("FAIL random t=%0t got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", $time, ack, door_open, locked, busy, state_out, exp_ack, exp_door, exp_locked, exp_busy, exp_state);
      end
      for (int g = 0; g < N; g++) begin
        r = 1'(req >> g);
        if (r && 1'(ack >> g)) begin
          if ($urandom_range(0, 3) != 0) req = req & ~(N'(1) << g);
        end else if (!r && $urandom_range(0, 5) == 0) begin
          c = ($urandom_range(0, 1) == 1) ? VC : 4'($urandom_range(0, 15));
          code_in = (code_in & ~((4*N)'(4'hF) << (4*g))) | ((4*N)'(c) << (4*g));
          req = req | (N'(1) << g);
        end
      end
    end
    req = '0;
    for (int k = 0; k < 12; k++) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_open();
    test_lockout();
    test_fail_clear();
    test_busy_pending();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
